// File: rtl/dht_access_sched.sv
// DHT11 access scheduler: read spacing, response timeout and
// a cached last reading that answers repeat requests while fresh.
module dht_access_sched #(
  parameter int unsigned MIN_INTERVAL = 100000000,
  parameter int unsigned MAX_AGE      = 100000000,
  parameter int unsigned TIMEOUT      = 2500000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Req_Start,
  input  logic [31:0] i_Dth_Data,
  input  logic        i_Dth_Done,
  input  logic        i_Dth_Error,
  output logic        o_Dth_Start,
  output logic [31:0] o_Req_Data,
  output logic        o_Req_Done,
  output logic        o_Req_Error,
  output logic        o_Busy,
  output logic        o_Cache_Valid
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_GAP,
    START,
    WAIT_SENSOR,
    RESP_OK,
    RESP_ERR,
    HOLD
  } state_t;

  localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(MIN_INTERVAL);
  localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(MAX_AGE);
  localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] age_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic             cache_valid;

  logic fresh;
  logic gap_ok;
  logic fail;
  logic capture;
  logic abort;

  assign fresh   = cache_valid && (age_cnt < AGE_MAX);
  assign gap_ok  = gap_cnt >= GAP_MAX;
  assign fail    = i_Dth_Error || (to_cnt >= TO_LAST);
  assign capture = (state == WAIT_SENSOR) && i_Dth_Done;
  assign abort   = (state == WAIT_SENSOR) && !i_Dth_Done && fail;

  assign o_Busy        = (state != IDLE);
  assign o_Cache_Valid = cache_valid;

  // Next-state decode; a dropped request abandons only pre-start states
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (i_Req_Start) state_nxt = CHECK;
      end
      CHECK: begin
        if (!i_Req_Start)  state_nxt = IDLE;
        else if (fresh)    state_nxt = RESP_OK;
        else if (gap_ok)   state_nxt = START;
        else               state_nxt = WAIT_GAP;
      end
      WAIT_GAP: begin
        if (!i_Req_Start)  state_nxt = IDLE;
        else if (gap_ok)   state_nxt = START;
      end
      START: begin
        state_nxt = WAIT_SENSOR;
      end
      WAIT_SENSOR: begin
        if (i_Dth_Done)
          state_nxt = i_Req_Start ? RESP_OK : IDLE;
        else if (fail)
          state_nxt = i_Req_Start ? RESP_ERR : IDLE;
      end
      RESP_OK: begin
        state_nxt = HOLD;
      end
      RESP_ERR: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (!i_Req_Start) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Saturating spacing, cache-age and response-timeout counters
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      gap_cnt <= '0;
      age_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      if (state == START)
        gap_cnt <= '0;
      else if (gap_cnt < GAP_MAX)
        gap_cnt <= gap_cnt + 1'b1;

      if (capture)
        age_cnt <= '0;
      else if (age_cnt < AGE_MAX)
        age_cnt <= age_cnt + 1'b1;

      if (state == START)
        to_cnt <= '0;
      else if (state == WAIT_SENSOR && to_cnt < TO_MAX)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  // Registered outputs and cache contents
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      o_Dth_Start <= 1'b0;
      o_Req_Data  <= '0;
      o_Req_Done  <= 1'b0;
      o_Req_Error <= 1'b0;
      cache_valid <= 1'b0;
    end else begin
      o_Dth_Start <= (state_nxt == WAIT_SENSOR);
      o_Req_Done  <= (state == RESP_OK);
      o_Req_Error <= (state == RESP_ERR);
      if (capture) begin
        o_Req_Data  <= i_Dth_Data;
        cache_valid <= 1'b1;
      end else if (abort) begin
        cache_valid <= 1'b0;
      end
    end
  end

endmodule
